// File: rtl/prim_word_packer_pkg.sv
// Shared definitions for the word packer and its downstream partners.
//   calc_cnt_w   : width needed to hold a beat count of 0..ratio
//   flush_stat_t : flush request / busy status pair reused by unpacker and
//                  status logic
package prim_word_packer_pkg;

  // Bits needed to represent 0..ratio. Never less than 1.
  function automatic int calc_cnt_w(input int ratio);
    return ((ratio + 1) <= 2) ? 1 : $clog2(ratio + 1);
  endfunction

  typedef struct packed {
    logic flush;
    logic busy;
  } flush_stat_t;

endpackage

// File: rtl/prim_word_packer_if.sv
// Beat-in / word-out bus of the word packer.
//   valid_i/ready_o/data_i : narrow input beat handshake
//   flush_i                : single-cycle request to emit the partial word
//   wvalid_o/wready_i      : FIFO write handshake
//   wdata_o/wlen_o         : packed word and its number of valid beats
//   busy_o                 : packer still holds data or a pending flush
// The slave modport is the packer; the master modport is the beat source
// together with the FIFO write port.
interface prim_word_packer_if #(
  parameter int InW  = 8,
  parameter int OutW = 32
) ();
  import prim_word_packer_pkg::*;

  localparam int Ratio = OutW / InW;
  localparam int CntW  = calc_cnt_w(Ratio);

  logic            valid_i;
  logic            ready_o;
  logic [InW-1:0]  data_i;
  logic            flush_i;
  logic            wvalid_o;
  logic            wready_i;
  logic [OutW-1:0] wdata_o;
  logic [CntW-1:0] wlen_o;
  logic            busy_o;

  modport slave (
    input  valid_i, data_i, flush_i, wready_i,
    output ready_o, wvalid_o, wdata_o, wlen_o, busy_o
  );

  modport master (
    output valid_i, data_i, flush_i, wready_i,
    input  ready_o, wvalid_o, wdata_o, wlen_o, busy_o
  );

endinterface

// File: rtl/prim_word_packer.sv
// Packs InW-bit beats LSB-first into OutW-bit words and pushes each word,
// together with its beat count, into a FIFO write port. A flush emits the
// current partial word with the unused upper beats forced to zero.
//   clk_i : clock
//   rst_i : synchronous active-high reset (wins over clr_i)
//   clr_i : synchronous clear of partial word, output word and pending flush
//   bus   : prim_word_packer_if.slave (beat input, flush, FIFO write side)
module prim_word_packer
  import prim_word_packer_pkg::*;
#(
  parameter int InW  = 8,
  parameter int OutW = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  prim_word_packer_if.slave  bus
);

  localparam int Ratio = OutW / InW;
  localparam int CntW  = calc_cnt_w(Ratio);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t CntLast = cnt_t'(Ratio - 1);
  localparam cnt_t CntFull = cnt_t'(Ratio);

  if (((OutW % InW) != 0) || ((OutW / InW) < 2)) begin : g_bad_ratio
    $error("prim_word_packer: OutW must be a multiple of InW with OutW/InW >= 2");
  end

  logic [OutW-1:0] acc_q;
  cnt_t            cnt_q;
  logic [OutW-1:0] out_data_q;
  cnt_t            out_len_q;
  logic            out_valid_q;
  logic            flush_pend_q;

  logic            slot_free;
  logic            cnt_last;
  logic            ready;
  logic            accept;
  logic            complete;
  logic            flush_go;
  logic            flush_drop;

  logic [Ratio-1:0] lane_we;
  logic [Ratio-1:0] lane_live;
  logic [OutW-1:0]  acc_merged;
  logic [OutW-1:0]  acc_partial;

  flush_stat_t stat;

  // Output slot can take a new word if empty or draining this cycle.
  assign slot_free = ~out_valid_q | bus.wready_i;
  assign cnt_last  = (cnt_q == CntLast);

  // The completing beat is only taken when it can go straight to the output
  // register, so the accumulator never needs a "full, waiting" state.
  assign ready    = ~flush_pend_q & ~(cnt_last & ~slot_free);
  assign accept   = bus.valid_i & ready;
  assign complete = accept & cnt_last;

  // ready is low while a flush is pending, so flush_go never coincides with
  // an accepted beat or a completed word.
  assign flush_go   = flush_pend_q & (cnt_q != '0) & slot_free;
  assign flush_drop = flush_pend_q & (cnt_q == '0);

  // Per-lane write enable and merge. lane_live masks lanes at or above cnt
  // so a partial word never leaks stale bytes left behind by a clear.
  for (genvar i = 0; i < Ratio; i++) begin : g_lane
    assign lane_we[i]   = accept & (cnt_q == cnt_t'(i));
    assign lane_live[i] = (cnt_t'(i) < cnt_q);
    assign acc_merged[i*InW +: InW]  = lane_we[i] ? bus.data_i
                                                  : acc_q[i*InW +: InW];
    assign acc_partial[i*InW +: InW] = lane_live[i] ? acc_q[i*InW +: InW]
                                                    : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_len_q    <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else if (clr_i) begin
      // Data registers are left as-is; len/valid/cnt make them invisible.
      cnt_q        <= '0;
      out_len_q    <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (complete) begin
        out_data_q  <= acc_merged;
        out_len_q   <= CntFull;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        cnt_q       <= '0;
      end else if (flush_go) begin
        out_data_q  <= acc_partial;
        out_len_q   <= cnt_q;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        cnt_q       <= '0;
      end else begin
        acc_q <= acc_merged;
        if (accept) cnt_q <= cnt_q + cnt_t'(1);
        if (bus.wready_i) out_valid_q <= 1'b0;
      end
      // A flush raised together with the completing beat stays pending one
      // cycle, finds cnt==0 and retires without emitting anything.
      flush_pend_q <= bus.flush_i | (flush_pend_q & ~(flush_go | flush_drop));
    end
  end

  always_comb begin
    stat       = '0;
    stat.flush = flush_pend_q;
    stat.busy  = out_valid_q | (cnt_q != '0) | flush_pend_q;
  end

  assign bus.ready_o  = ready;
  assign bus.wvalid_o = out_valid_q;
  assign bus.wdata_o  = out_data_q;
  assign bus.wlen_o   = out_len_q;
  assign bus.busy_o   = stat.busy;

  // A word offered to the FIFO stays put until it is taken.
  a_wvalid_stable: assert property (@(posedge clk_i)
    (bus.wvalid_o && !bus.wready_i && !rst_i && !clr_i) |=>
      (bus.wvalid_o && $stable(bus.wdata_o) && $stable(bus.wlen_o)));

  a_wlen_nonzero: assert property (@(posedge clk_i)
    bus.wvalid_o |-> (bus.wlen_o != '0));

  a_cnt_range: assert property (@(posedge clk_i) cnt_q <= CntLast);

endmodule

// File: tb/tb_prim_word_packer.sv
module tb_prim_word_packer;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  prim_word_packer_if #(.InW(8), .OutW(32)) bus ();

  prim_word_packer #(.InW(8), .OutW(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  len;
  } exp_t;

  exp_t sb[$];
  int   ntot  = 0;
  int   npass = 0;
  int   nfail = 0;

  logic        hold = 1'b0;
  logic [31:0] hold_data;
  logic [2:0]  hold_len;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [31:0] d, input logic [2:0] l);
    exp_t e;
    e.data = d;
    e.len  = l;
    sb.push_back(e);
  endtask

  // Present one beat and return one tick after it is accepted; valid_i is
  // left high so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] d, output int waits);
    waits = 0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    @(negedge clk);
    while (!bus.ready_o && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 100) begin
      ntot++;
      nfail++;
      $error("FAIL send_timeout: observed ready_o=0 expected ready_o=1 (beat %0h)", d);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold checks on the FIFO side.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold) begin
        check("hold_vld",  bus.wvalid_o, 1);
        check("hold_data", bus.wdata_o, hold_data);
        check("hold_len",  bus.wlen_o, hold_len);
      end
      if (bus.wvalid_o) check("wlen_nz", (bus.wlen_o != 3'd0), 1);
      if (bus.wvalid_o && bus.wready_i) begin
        ntot++;
        assert (sb.size() > 0) npass++;
        else begin
          nfail++;
          $error("FAIL unexpected_word: observed %0h/%0d expected no word",
                 bus.wdata_o, bus.wlen_o);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data", bus.wdata_o, e.data);
          check("sb_len",  bus.wlen_o, e.len);
        end
      end
      hold      = bus.wvalid_o & ~bus.wready_i & ~clr;
      hold_data = bus.wdata_o;
      hold_len  = bus.wlen_o;
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    clr = 1'b0;
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.flush_i  = 1'b0;
    bus.wready_i = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wvalid", bus.wvalid_o, 0);
    check("rst_wdata",  bus.wdata_o, 0);
    check("rst_wlen",   bus.wlen_o, 0);
    check("rst_busy",   bus.busy_o, 0);
    check("rst_ready",  bus.ready_o, 1);

    // Single word, one-cycle latency
    tick();
    bus.wready_i = 1'b1;
    exp_word(32'h44332211, 3'd4);
    send(8'h11, w); send(8'h22, w); send(8'h33, w); send(8'h44, w);
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("t1_lat_vld",  bus.wvalid_o, 1);
    check("t1_lat_data", bus.wdata_o, 32'h44332211);
    check("t1_lat_len",  bus.wlen_o, 4);
    tick(3);

    // Back-to-back words at full rate
    exp_word(32'h04030201, 3'd4);
    exp_word(32'h08070605, 3'd4);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), w);
      check("t2_ready_wait", w, 0);
    end
    bus.valid_i = 1'b0;
    tick(4);

    // Partial word flush
    exp_word(32'h00CCBBAA, 3'd3);
    send(8'hAA, w); send(8'hBB, w); send(8'hCC, w);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("t3_ready_pend", bus.ready_o, 0);
    check("t3_busy_pend",  bus.busy_o, 1);
    tick();
    @(negedge clk);
    check("t3_wvalid", bus.wvalid_o, 1);
    check("t3_wlen",   bus.wlen_o, 3);
    tick();
    @(negedge clk);
    check("t3_busy_done", bus.busy_o, 0);
    tick();

    // Backpressure: word held, extra beat accepted, flush waits for drain
    bus.wready_i = 1'b0;
    exp_word(32'hA4A3A2A1, 3'd4);
    send(8'hA1, w); send(8'hA2, w); send(8'hA3, w); send(8'hA4, w);
    send(8'h55, w);
    check("t4_beat5_wait", w, 0);
    bus.valid_i = 1'b0;
    tick(3);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("t4_ready_pend", bus.ready_o, 0);
    tick(2);
    @(negedge clk);
    check("t4_held_vld",  bus.wvalid_o, 1);
    check("t4_held_data", bus.wdata_o, 32'hA4A3A2A1);
    check("t4_busy",      bus.busy_o, 1);
    exp_word(32'h00000055, 3'd1);
    tick();
    bus.wready_i = 1'b1;
    tick();
    @(negedge clk);
    check("t4_flush_vld",  bus.wvalid_o, 1);
    check("t4_flush_data", bus.wdata_o, 32'h00000055);
    check("t4_flush_len",  bus.wlen_o, 1);
    tick();
    @(negedge clk);
    check("t4_busy_done", bus.busy_o, 0);
    tick();

    // Completing beat stalls while the output register is full
    bus.wready_i = 1'b0;
    exp_word(32'hB4B3B2B1, 3'd4);
    exp_word(32'hB8B7B6B5, 3'd4);
    for (int i = 1; i <= 7; i++) send(8'hB0 + 8'(i), w);
    bus.data_i = 8'hB8;
    repeat (3) begin
      @(negedge clk);
      check("t4b_ready_stall", bus.ready_o, 0);
    end
    tick();
    bus.wready_i = 1'b1;
    @(negedge clk);
    check("t4b_ready_free", bus.ready_o, 1);
    tick();
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("t4b_w2_vld",  bus.wvalid_o, 1);
    check("t4b_w2_data", bus.wdata_o, 32'hB8B7B6B5);
    tick(2);

    // Flush with empty accumulator
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    tick();
    @(negedge clk);
    check("t5_busy",   bus.busy_o, 0);
    check("t5_wvalid", bus.wvalid_o, 0);
    tick();

    // Reset mid-word
    send(8'hE1, w); send(8'hE2, w);
    bus.valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_wvalid", bus.wvalid_o, 0);
    check("t6_wdata",  bus.wdata_o, 0);
    check("t6_wlen",   bus.wlen_o, 0);
    check("t6_busy",   bus.busy_o, 0);
    check("t6_ready",  bus.ready_o, 1);
    tick();
    exp_word(32'h04030201, 3'd4);
    send(8'h01, w); send(8'h02, w); send(8'h03, w); send(8'h04, w);
    bus.valid_i = 1'b0;
    tick(3);

    // Clear mid-word; the later partial flush must not pick up stale lanes
    send(8'hE1, w); send(8'hE2, w); send(8'hE3, w);
    bus.valid_i = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("t7_busy",   bus.busy_o, 0);
    check("t7_wvalid", bus.wvalid_o, 0);
    check("t7_ready",  bus.ready_o, 1);
    tick();
    exp_word(32'h000000C1, 3'd1);
    send(8'hC1, w);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    tick(3);
    exp_word(32'h0D0C0B0A, 3'd4);
    send(8'h0A, w); send(8'h0B, w); send(8'h0C, w); send(8'h0D, w);
    bus.valid_i = 1'b0;
    tick(3);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
